// File: rtl/firebird7_in_gate1_tessent_sib_pkg.sv
// Shared types for the firebird7_in_gate1 secure SIB controller: FSM state
// encoding (equal to the 2-bit capture codes) and the fail-counter width.
package firebird7_in_gate1_tessent_sib_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_BLOCKED  = 2'b10
    } sib_state_e;

    localparam int FAIL_CNT_W = 3;
    localparam logic [FAIL_CNT_W-1:0] FAIL_CNT_SAT = '1;

endpackage

// File: rtl/firebird7_in_gate1_tessent_sib_key_check.sv
// Key comparator plus saturating fail counter. fail_limit_o flags that one more
// mismatching attempt brings the count to MAX_FAILS.
module firebird7_in_gate1_tessent_sib_key_check
    import firebird7_in_gate1_tessent_sib_pkg::*;
#(
    parameter int                    KEY_WIDTH = 16,
    parameter logic [KEY_WIDTH-1:0]  KEY_VALUE = 16'hA5C3,
    parameter int                    MAX_FAILS = 3
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic [KEY_WIDTH-1:0] key_i,
    input  logic                 attempt_i,
    output logic                 key_match_o,
    output logic                 fail_limit_o
);

    localparam logic [FAIL_CNT_W:0] FAIL_LIMIT = (FAIL_CNT_W+1)'(MAX_FAILS);

    logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    assign key_match_o  = (key_i == KEY_VALUE);
    assign fail_limit_o = (({1'b0, fail_cnt_q} + 1'b1) == FAIL_LIMIT);

    always_comb begin
        fail_cnt_d = fail_cnt_q;
        if (attempt_i) begin
            if (key_match_o) begin
                fail_cnt_d = '0;
            end else if (fail_cnt_q != FAIL_CNT_SAT) begin
                fail_cnt_d = fail_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            fail_cnt_q <= '0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end

endmodule

// File: rtl/firebird7_in_gate1_tessent_sib_sti_secure_ctrl.sv
// Secure segment-select scan register for the firebird7_in_gate1 IJTAG network.
// Key gating is built only with FIREBIRD7_IN_GATE1_SIB_SECURE_KEY_EN defined.
module firebird7_in_gate1_tessent_sib_sti_secure_ctrl
    import firebird7_in_gate1_tessent_sib_pkg::*;
#(
    parameter int                    KEY_WIDTH = 16,
    parameter logic [KEY_WIDTH-1:0]  KEY_VALUE = 16'hA5C3,
    parameter int                    MAX_FAILS = 3
) (
    input  logic ijtag_tck,
    input  logic ijtag_reset,
    input  logic ijtag_sel,
    input  logic ijtag_ce,
    input  logic ijtag_se,
    input  logic ijtag_ue,
    input  logic ijtag_si,
    output logic ijtag_so,
    output logic mux_select,
    output logic secure_unlocked,
    output logic secure_blocked
);

`ifdef FIREBIRD7_IN_GATE1_SIB_SECURE_KEY_EN

    localparam int W = KEY_WIDTH + 1;

    sib_state_e state_q, state_d;
    logic [W-1:0] sr_q, sr_d;
    logic mux_q, mux_d;
    logic unlocked_q, blocked_q;
    logic attempt, key_match, fail_limit;

    firebird7_in_gate1_tessent_sib_key_check #(
        .KEY_WIDTH (KEY_WIDTH),
        .KEY_VALUE (KEY_VALUE),
        .MAX_FAILS (MAX_FAILS)
    ) u_key_check (
        .clk_i        (ijtag_tck),
        .srst_i       (ijtag_reset),
        .key_i        (sr_q[W-1:1]),
        .attempt_i    (attempt),
        .key_match_o  (key_match),
        .fail_limit_o (fail_limit)
    );

    always_comb begin
        sr_d    = sr_q;
        mux_d   = mux_q;
        state_d = state_q;
        attempt = 1'b0;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d      = '0;
                sr_d[0]   = mux_q;
                sr_d[2:1] = state_q;
            end else if (ijtag_se) begin
                sr_d = {ijtag_si, sr_q[W-1:1]};
            end else if (ijtag_ue && (state_q != ST_BLOCKED)) begin
                // Closing is always honoured; opening from LOCKED costs an attempt.
                if (!sr_q[0]) begin
                    mux_d = 1'b0;
                end else if (state_q == ST_UNLOCKED) begin
                    mux_d = 1'b1;
                end else begin
                    attempt = 1'b1;
                    if (key_match) begin
                        state_d = ST_UNLOCKED;
                        mux_d   = 1'b1;
                    end else if (fail_limit) begin
                        state_d = ST_BLOCKED;
                    end
                end
            end
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr_q       <= '0;
            mux_q      <= 1'b0;
            state_q    <= ST_LOCKED;
            unlocked_q <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            mux_q      <= mux_d;
            state_q    <= state_d;
            unlocked_q <= (state_d == ST_UNLOCKED);
            blocked_q  <= (state_d == ST_BLOCKED);
        end
    end

    assign ijtag_so        = sr_q[0];
    assign mux_select      = mux_q;
    assign secure_unlocked = unlocked_q;
    assign secure_blocked  = blocked_q;

`else

    logic sr_q, sr_d;
    logic mux_q, mux_d;
    logic cfg_unused;

    // Key parameters have no function in the plain SIB build.
    assign cfg_unused = ^{KEY_VALUE, MAX_FAILS};

    always_comb begin
        sr_d  = sr_q;
        mux_d = mux_q;
        if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_d = mux_q;
            end else if (ijtag_se) begin
                sr_d = ijtag_si;
            end else if (ijtag_ue) begin
                mux_d = sr_q;
            end
        end
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr_q  <= 1'b0;
            mux_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            mux_q <= mux_d;
        end
    end

    assign ijtag_so        = sr_q;
    assign mux_select      = mux_q;
    assign secure_unlocked = 1'b1;
    assign secure_blocked  = 1'b0;

`endif

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_sib_sti_secure_ctrl.sv
// Bench for the secure SIB controller: vector table, hand sequences and a
// randomized run against a behavioural model; works with or without the key macro.
module tb_firebird7_in_gate1_tessent_sib_sti_secure_ctrl;

`ifdef FIREBIRD7_IN_GATE1_SIB_SECURE_KEY_EN
    localparam int W = 17;
`else
    localparam int W = 1;
`endif
    localparam int KEY         = 16'hA5C3;
    localparam int MAXF        = 3;
    localparam int UNLOCK_WORD = (KEY << 1) | 1;

    logic ijtag_tck = 1'b0;
    logic ijtag_reset, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si;
    logic ijtag_so, mux_select, secure_unlocked, secure_blocked;

    firebird7_in_gate1_tessent_sib_sti_secure_ctrl #(
        .KEY_WIDTH (16),
        .KEY_VALUE (16'hA5C3),
        .MAX_FAILS (MAXF)
    ) dut (
        .ijtag_tck       (ijtag_tck),
        .ijtag_reset     (ijtag_reset),
        .ijtag_sel       (ijtag_sel),
        .ijtag_ce        (ijtag_ce),
        .ijtag_se        (ijtag_se),
        .ijtag_ue        (ijtag_ue),
        .ijtag_si        (ijtag_si),
        .ijtag_so        (ijtag_so),
        .mux_select      (mux_select),
        .secure_unlocked (secure_unlocked),
        .secure_blocked  (secure_blocked)
    );

    always #5 ijtag_tck = ~ijtag_tck;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: register contents as an integer, state as 0=locked 1=unlocked 2=blocked.
    int m_sr, m_mux, m_state, m_fails;

    typedef struct {
        bit rst, sel, ce, se, ue, si;
        logic [3:0] exp;   // {so, mux_select, secure_unlocked, secure_blocked}
    } vec_t;

    function automatic void model_step(bit rst, bit sel, bit ce, bit se, bit ue, bit si);
        if (rst) begin
            m_sr = 0; m_mux = 0; m_state = 0; m_fails = 0;
        end else if (sel) begin
`ifdef FIREBIRD7_IN_GATE1_SIB_SECURE_KEY_EN
            if (ce) m_sr = (m_state * 2) + m_mux;
            else if (se) m_sr = (m_sr / 2) + (int'(si) << (W - 1));
            else if (ue && m_state != 2) begin
                if (m_sr % 2 == 0) m_mux = 0;
                else if (m_state == 1) m_mux = 1;
                else if (m_sr / 2 == KEY) begin
                    m_state = 1; m_mux = 1; m_fails = 0;
                end else begin
                    if (m_fails < 7) m_fails = m_fails + 1;
                    if (m_fails == MAXF) m_state = 2;
                end
            end
`else
            if (ce) m_sr = m_mux;
            else if (se) m_sr = int'(si);
            else if (ue) m_mux = m_sr;
`endif
        end
    endfunction

    function automatic logic [3:0] model_out();
`ifdef FIREBIRD7_IN_GATE1_SIB_SECURE_KEY_EN
        return {m_sr[0], m_mux[0], m_state == 1, m_state == 2};
`else
        return {m_sr[0], m_mux[0], 1'b1, 1'b0};
`endif
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got so/mux/unl/blk=%b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit sel, input bit ce, input bit se,
                        input bit ue, input bit si);
        ijtag_reset = rst; ijtag_sel = sel; ijtag_ce = ce;
        ijtag_se = se; ijtag_ue = ue; ijtag_si = si;
        @(posedge ijtag_tck);
        #1;
        model_step(rst, sel, ce, se, ue, si);
        chk("model", {ijtag_so, mux_select, secure_unlocked, secure_blocked}, model_out());
        $display("step rst=%0b sel=%0b ce=%0b se=%0b ue=%0b si=%0b -> so=%0b mux=%0b unl=%0b blk=%0b",
                 rst, sel, ce, se, ue, si, ijtag_so, mux_select, secure_unlocked, secure_blocked);
    endtask

    task automatic shift_word(input int unsigned val, input int nbits);
        for (int i = 0; i < nbits; i++) step(0, 1, 0, 1, 0, val[i]);
    endtask

    function automatic logic [3:0] outs();
        return {ijtag_so, mux_select, secure_unlocked, secure_blocked};
    endfunction

    vec_t tbl[$];

    initial begin
`ifdef FIREBIRD7_IN_GATE1_SIB_SECURE_KEY_EN
        tbl.push_back('{0, 0, 0, 1, 1, 1, 4'b0000});
        tbl.push_back('{0, 1, 0, 1, 0, 1, 4'b0000});
        tbl.push_back('{0, 1, 1, 1, 1, 1, 4'b0000});
        tbl.push_back('{0, 1, 0, 1, 0, 1, 4'b0000});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 4'b0000});
        tbl.push_back('{1, 1, 0, 1, 0, 1, 4'b0000});
`else
        tbl.push_back('{0, 0, 0, 1, 0, 1, 4'b0010});
        tbl.push_back('{0, 1, 0, 1, 0, 1, 4'b1010});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 4'b1010});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 4'b1110});
        tbl.push_back('{0, 1, 0, 1, 0, 0, 4'b0110});
        tbl.push_back('{0, 1, 1, 1, 1, 0, 4'b1110});
        tbl.push_back('{0, 1, 0, 1, 0, 0, 4'b0110});
        tbl.push_back('{0, 1, 0, 0, 1, 0, 4'b0010});
        tbl.push_back('{0, 1, 0, 1, 0, 1, 4'b1010});
        tbl.push_back('{1, 1, 0, 0, 1, 0, 4'b0010});
`endif
        m_sr = 0; m_mux = 0; m_state = 0; m_fails = 0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].sel, tbl[i].ce, tbl[i].se, tbl[i].ue, tbl[i].si);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

`ifdef FIREBIRD7_IN_GATE1_SIB_SECURE_KEY_EN
        // Reset, capture, then 17 shifts stream zeros out.
        step(1, 0, 0, 0, 0, 0);
        chk("reset_state", outs(), 4'b0000);
        step(0, 1, 1, 0, 0, 0);
        chk("capture_locked", outs(), 4'b0000);
        for (int i = 0; i < W; i++) begin
            step(0, 1, 0, 1, 0, 0);
            chk($sformatf("so_stream%0d", i), outs(), 4'b0000);
        end

        // Correct key unlocks; capture reports 3'b011.
        shift_word(UNLOCK_WORD, W);
        step(0, 1, 0, 0, 1, 0);
        chk("unlock", outs(), 4'b1110);
        step(0, 1, 1, 0, 0, 0);
        chk("capture_unl_b0", outs(), 4'b1110);
        step(0, 1, 0, 1, 0, 0);
        chk("capture_unl_b1", outs(), 4'b1110);
        step(0, 1, 0, 1, 0, 0);
        chk("capture_unl_b2", outs(), 4'b0110);

        // Three wrong attempts block; correct key is then refused.
        step(1, 0, 0, 0, 0, 0);
        shift_word(32'h1, W);
        step(0, 1, 0, 0, 1, 0);
        chk("fail1", outs(), 4'b1000);
        step(0, 1, 0, 0, 1, 0);
        chk("fail2", outs(), 4'b1000);
        step(0, 1, 0, 0, 1, 0);
        chk("fail3_blocked", outs(), 4'b1001);
        shift_word(UNLOCK_WORD, W);
        step(0, 1, 0, 0, 1, 0);
        chk("blocked_refuses_key", outs(), 4'b1001);

        // From UNLOCKED: close keeps state, reopen ignores key.
        step(1, 0, 0, 0, 0, 0);
        shift_word(UNLOCK_WORD, W);
        step(0, 1, 0, 0, 1, 0);
        shift_word(32'h0, W);
        step(0, 1, 0, 0, 1, 0);
        chk("close_unlocked", outs(), 4'b0010);
        shift_word(32'h2469, W);
        step(0, 1, 0, 0, 1, 0);
        chk("reopen_any_key", outs(), 4'b1110);

        // Reset partway through a key shift.
        shift_word(UNLOCK_WORD, 8);
        step(1, 1, 0, 1, 0, 1);
        chk("reset_mid_shift", outs(), 4'b0000);
        shift_word(UNLOCK_WORD, W);
        step(0, 1, 0, 0, 1, 0);
        chk("unlock_after_reset", outs(), 4'b1110);
`else
        step(1, 0, 0, 0, 0, 0);
        chk("reset_state", outs(), 4'b0010);
        shift_word(32'h1, W);
        step(0, 1, 0, 0, 1, 0);
        chk("open", outs(), 4'b1110);
        shift_word(32'h0, W);
        chk("shift0", outs(), 4'b0110);
        step(0, 1, 0, 0, 1, 0);
        chk("close", outs(), 4'b0010);
`endif

        // Randomized sessions: key shifts, updates, then free-running controls.
        for (int k = 0; k < 40; k++) begin
            int unsigned word;
            if ($urandom_range(9) == 0) step(1, $urandom_range(1), 0, 0, 0, 0);
            case ($urandom_range(3))
                0, 1: word = UNLOCK_WORD;
                2:    word = ($urandom_range(16'hFFFF) << 1) | 1;
                default: word = $urandom_range(16'hFFFF) << 1;
            endcase
            shift_word(word, W);
            for (int u = 0; u < int'($urandom_range(3)); u++)
                step(0, $urandom_range(3) != 0, 0, 0, 1, 0);
            for (int c = 0; c < 8; c++)
                step($urandom_range(19) == 0, $urandom_range(9) != 0,
                     $urandom_range(9) == 0, $urandom_range(1),
                     $urandom_range(4) == 0, $urandom_range(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/firebird7_in_gate1_tessent_sib_sti_secure_ctrl.md
# firebird7_in_gate1_tessent_sib_sti_secure_ctrl

IJTAG secure segment-select controller: the scan register that produces `mux_select` for the secure scan mux, gating its sub-segment behind a shifted-in key. It sits in the `firebird7_in_gate1` IJTAG network between the parent scan path and the secure mux. It runs capture/shift/update on the network's control signals and opens the segment only after a correct key. Repeated wrong keys lock the segment until reset.

## Interface
Parameters:
- `KEY_WIDTH`, 16: key field width in bits, minimum 2.
- `KEY_VALUE`, 16'hA5C3: unlock key.
- `MAX_FAILS`, 3: mismatching unlock attempts before the block enters BLOCKED; range 1..7.

Ports:
- `ijtag_tck` input 1: sole clock, rising edge.
- `ijtag_reset` input 1: reset, synchronous and active-high.
- `ijtag_sel` input 1: this register is on the active scan path.
- `ijtag_ce` input 1: capture enable.
- `ijtag_se` input 1: shift enable.
- `ijtag_ue` input 1: update enable.
- `ijtag_si` input 1: scan in.
- `ijtag_so` output 1: scan out, equal to `sr[0]`.
- `mux_select` output 1: registered select driven to the secure mux.
- `secure_unlocked` output 1: FSM is in UNLOCKED.
- `secure_blocked` output 1: FSM is in BLOCKED.

## Operation
- Shift register `sr`, width `W = KEY_WIDTH+1`:
  - `sr[0]` is the select bit (closest to `ijtag_so`).
  - `sr[W-1:1]` is the key field.
- All actions require `ijtag_sel=1`. Priority is capture > shift > update; only one action per cycle.
- Capture: `sr[0] <= mux_select`, `sr[2:1] <=` state code, all other bits 0.
- Shift: `sr <= {ijtag_si, sr[W-1:1]}`.
- State codes: LOCKED=2'b00, UNLOCKED=2'b01, BLOCKED=2'b10.
- Update in BLOCKED: no effect; `mux_select` stays 0.
- Update with `sr[0]=0`: `mux_select <= 0`; state unchanged. Closing the segment is always allowed.
- Update with `sr[0]=1` in UNLOCKED: `mux_select <= 1`.
- Update with `sr[0]=1` in LOCKED:
  - Key match (`sr[W-1:1]==KEY_VALUE`): go to UNLOCKED, `mux_select <= 1`, fail counter cleared.
  - Mismatch: fail counter increments, `mux_select` stays 0. If the new count equals `MAX_FAILS`, go to BLOCKED.
- Fail counter: 3 bits, saturating, cleared only by reset or by a successful unlock.
- BLOCKED exits only by reset.
- With `ijtag_sel=0`, all state holds, including during `ce`/`se`/`ue`.

## Timing
- Reset values: `sr=0`, `ijtag_so=0`, `mux_select=0`, state LOCKED, fail count 0, `secure_unlocked=0`, `secure_blocked=0`.
- Reset overrides any concurrent capture, shift or update. Reset during a shift discards the partial key.
- Each action takes effect on the `ijtag_tck` edge where its enable is sampled.
  - `mux_select`, `secure_*` and state change one edge after `ue` is sampled.
  - `ijtag_so` changes one edge after `se` or `ce` is sampled.
- `secure_unlocked` and `secure_blocked` are registered decodes of the state; no combinational path from inputs.
- A full unlock takes W shift cycles plus one update cycle.

## Configuration
- Macro: `FIREBIRD7_IN_GATE1_SIB_SECURE_KEY_EN`.
- Defined: behaviour exactly as above.
- Undefined:
  - `W=1`; there is no key field, FSM or fail counter.
  - Update loads `sr[0]` directly into `mux_select`.
  - Capture loads `mux_select` into `sr[0]`.
  - `secure_unlocked` is tied to 1 and `secure_blocked` to 0.
  - `KEY_VALUE` and `MAX_FAILS` are ignored.

## Structure
- Package `firebird7_in_gate1_tessent_sib_pkg` holds:
  - the state enum (LOCKED/UNLOCKED/BLOCKED) with its 2-bit capture codes;
  - the fail-counter width constant (3).
- One sub-module, `firebird7_in_gate1_tessent_sib_key_check`: key comparator plus saturating fail counter. Outputs `key_match` and `fail_limit`; instantiated only when the macro is defined.
- The top holds the shift register, update logic and FSM.

## Test plan
All with defaults `KEY_WIDTH=16`, `KEY_VALUE=16'hA5C3`, `MAX_FAILS=3`, macro defined unless stated.
- Reset, then capture then 17 shifts: `ijtag_so` sequence is 0, 0, 0, … (state LOCKED, select 0).
- Shift 17'h14B87 (key A5C3, select 1), then update: `mux_select=1` and `secure_unlocked=1` one edge later. A following capture yields `sr[2:0]=3'b011`.
- Shift key 16'h0000 with select 1, update three times: after 2 updates fail count is 2 and `mux_select=0`; after the 3rd, `secure_blocked=1`. A later correct key leaves `mux_select=0`.
- From UNLOCKED, update with select 0: `mux_select=0` and state stays UNLOCKED. Update with select 1 and any key: `mux_select=1`.
- Assert `ijtag_reset` mid-shift after 8 of 17 bits: all outputs return to reset values on the next edge. A fresh full shift then unlocks normally.
- Macro undefined: shift 1, update gives `mux_select=1`; shift 0, update gives 0. `secure_unlocked` stays 1 throughout.
